alu_operand_stage: RTL and testbench



---
 rtl/alu_pkg.sv | 12 +
 rtl/regfile32.sv | 49 ++++
 rtl/alu_operand_stage.sv | 97 +++++++++
 tb/tb_alu_operand_stage.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue path: operand/address widths and ALU op codes.
package alu_pkg;

  localparam int DW = 32;
  localparam int AW = 5;

  localparam logic [1:0] ALUC_AND = 2'b00;
  localparam logic [1:0] ALUC_OR  = 2'b01;
  localparam logic [1:0] ALUC_ADD = 2'b10;
  localparam logic [1:0] ALUC_SUB = 2'b11;

endpackage

// File: rtl/regfile32.sv
// Register file with two combinational read ports and one write port.
// r0 reads as zero, and a same-cycle write is bypassed to the read ports.
module regfile32 #(
  parameter int NREG = 32,
  parameter int AW   = alu_pkg::AW,
  parameter int DW   = alu_pkg::DW
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2
);

  logic [DW-1:0] regs [NREG];

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  always_comb begin
    rd1 = regs[ra1];
    if (ra1 == '0) begin
      rd1 = '0;
    end else if (we && (wa == ra1)) begin
      rd1 = wd;
    end
  end

  always_comb begin
    rd2 = regs[ra2];
    if (ra2 == '0) begin
      rd2 = '0;
    end else if (we && (wa == ra2)) begin
      rd2 = wd;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Issue stage feeding the ALU: reads operands, tracks in-flight destinations
// in a pending scoreboard and presents a registered bundle over valid/ready.
module alu_operand_stage #(
  parameter int NREG = 32,
  parameter int AW   = alu_pkg::AW,
  parameter int DW   = alu_pkg::DW
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_aluc,
  input  logic [AW-1:0] in_rs,
  input  logic [AW-1:0] in_rt,
  input  logic [AW-1:0] in_rd,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] a,
  output logic [DW-1:0] b,
  output logic [1:0]    aluc,
  output logic [AW-1:0] rd,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_rd,
  input  logic [DW-1:0] wb_data
);

  logic [NREG-1:0] pend;
  logic [NREG-1:0] clr_vec;
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] pend_live;
  logic [DW-1:0]   rdata_a;
  logic [DW-1:0]   rdata_b;
  logic            hazard;
  logic            accept;

  regfile32 #(.NREG(NREG), .AW(AW), .DW(DW)) u_regfile (
    .clk  (clk),
    .clrn (clrn),
    .we   (wb_we),
    .wa   (wb_rd),
    .wd   (wb_data),
    .ra1  (in_rs),
    .ra2  (in_rt),
    .rd1  (rdata_a),
    .rd2  (rdata_b)
  );

  always_comb begin
    clr_vec = '0;
    if (wb_we) begin
      clr_vec[wb_rd] = 1'b1;
    end
  end

  // A register whose write-back lands this cycle is no longer a hazard.
  assign pend_live = pend & ~clr_vec;
  assign hazard    = ((in_rs != '0) && pend_live[in_rs]) ||
                     ((in_rt != '0) && pend_live[in_rt]) ||
                     ((in_rd != '0) && pend_live[in_rd]);
  assign in_ready  = (!out_valid || out_ready) && !hazard;
  assign accept    = in_valid && in_ready;

  always_comb begin
    set_vec = '0;
    if (accept && (in_rd != '0)) begin
      set_vec[in_rd] = 1'b1;
    end
  end

  // Set is OR-ed after the clear so a coincident re-issue keeps the bit.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      pend <= '0;
    end else begin
      pend <= pend_live | set_vec;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      out_valid <= 1'b0;
      a         <= '0;
      b         <= '0;
      aluc      <= '0;
      rd        <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      a         <= rdata_a;
      b         <= rdata_b;
      aluc      <= in_aluc;
      rd        <= in_rd;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: directed scenarios followed by
// random traffic, checked against a register/pending-set reference model.
module tb_alu_operand_stage;
  import alu_pkg::*;

  localparam int NREG = 32;
  localparam int AWL  = 5;
  localparam int DWL  = 32;

  typedef struct packed {
    logic [DWL-1:0] a;
    logic [DWL-1:0] b;
    logic [1:0]     aluc;
    logic [AWL-1:0] rd;
  } bundle_t;

  typedef struct packed {
    logic [AWL-1:0] rd;
    logic [DWL-1:0] data;
  } wb_t;

  logic           clk = 1'b0;
  logic           clrn;
  logic           in_valid;
  logic           in_ready;
  logic [1:0]     in_aluc;
  logic [AWL-1:0] in_rs;
  logic [AWL-1:0] in_rt;
  logic [AWL-1:0] in_rd;
  logic           out_valid;
  logic           out_ready;
  logic [DWL-1:0] a;
  logic [DWL-1:0] b;
  logic [1:0]     aluc;
  logic [AWL-1:0] rd;
  logic           wb_we;
  logic [AWL-1:0] wb_rd;
  logic [DWL-1:0] wb_data;

  bundle_t        exp_q[$];
  wb_t            alu_wb_q[$];
  logic [DWL-1:0] ref_regs [NREG];
  bit             ref_pend [NREG];
  int             checks = 0;
  int             errors = 0;

  always #5 clk = ~clk;

  alu_operand_stage #(.NREG(NREG), .AW(AWL), .DW(DWL)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_aluc   (in_aluc),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .in_rd     (in_rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a         (a),
    .b         (b),
    .aluc      (aluc),
    .rd        (rd),
    .wb_we     (wb_we),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data)
  );

  task automatic checkOutput(input string name, input logic [DWL-1:0] got, input logic [DWL-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [DWL-1:0] ref_read(input logic [AWL-1:0] r);
    if (r == 0) return '0;
    if (wb_we && (wb_rd == r)) return wb_data;
    return ref_regs[r];
  endfunction

  function automatic bit ref_blocked(input logic [AWL-1:0] r);
    return (r != 0) && ref_pend[r] && !(wb_we && (wb_rd == r));
  endfunction

  function automatic logic [DWL-1:0] alu_result(input bundle_t bnd);
    case (bnd.aluc)
      ALUC_AND: return bnd.a & bnd.b;
      ALUC_OR:  return bnd.a | bnd.b;
      ALUC_ADD: return bnd.a + bnd.b;
      default:  return bnd.a - bnd.b;
    endcase
  endfunction

  task automatic clearModel();
    for (int i = 0; i < NREG; i++) begin
      ref_regs[i] = '0;
      ref_pend[i] = 1'b0;
    end
    exp_q.delete();
    alu_wb_q.delete();
  endtask

  // One clock cycle: drive inputs, check in_ready against the model, then
  // retire the cycle into the model at the rising edge.
  task automatic applyStimulus(input logic iv, input logic [1:0] op, input logic [AWL-1:0] rs,
                               input logic [AWL-1:0] rt, input logic [AWL-1:0] rdd, input logic ordy,
                               input logic we, input logic [AWL-1:0] wrd, input logic [DWL-1:0] wdat);
    bit      exp_ready;
    bit      acc;
    bundle_t nb;
    @(negedge clk);
    #2;
    in_valid = iv; in_aluc = op; in_rs = rs; in_rt = rt; in_rd = rdd;
    out_ready = ordy; wb_we = we; wb_rd = wrd; wb_data = wdat;
    #1;
    exp_ready = ((exp_q.size() == 0) || ordy) && !ref_blocked(rs) && !ref_blocked(rt) && !ref_blocked(rdd);
    checkOutput("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
    acc = iv && exp_ready;
    nb.a = ref_read(rs);
    nb.b = ref_read(rt);
    nb.aluc = op;
    nb.rd = rdd;
    @(posedge clk);
    if (we && (wrd != 0)) begin
      ref_regs[wrd] = wdat;
      ref_pend[wrd] = 1'b0;
    end
    if (acc) begin
      exp_q.push_back(nb);
      if (rdd != 0) ref_pend[rdd] = 1'b1;
    end
  endtask

  task automatic idle(input logic ordy);
    applyStimulus(1'b0, 2'b00, '0, '0, '0, ordy, 1'b0, '0, '0);
  endtask

  // Monitor: just before each rising edge, compare the presented bundle with
  // the oldest expectation and retire it when the ALU side consumes it.
  initial begin : monitor
    bundle_t got_b;
    bundle_t exp_b;
    wb_t     res;
    forever begin
      @(negedge clk);
      #4;
      if (clrn === 1'b1) begin
        checks++;
        if (out_valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_out: out_valid 1 expected 0");
          end else begin
            got_b = {a, b, aluc, rd};
            exp_b = exp_q[0];
            if (got_b !== exp_b) begin
              errors++;
              $display("[TB] FAIL bundle: got a=%h b=%h aluc=%0d rd=%0d expected a=%h b=%h aluc=%0d rd=%0d",
                       a, b, aluc, rd, exp_b.a, exp_b.b, exp_b.aluc, exp_b.rd);
            end
            if (out_ready === 1'b1) begin
              void'(exp_q.pop_front());
              if (exp_b.rd != 0) begin
                res.rd = exp_b.rd;
                res.data = alu_result(exp_b);
                alu_wb_q.push_back(res);
              end
            end
          end
        end else if (exp_q.size() != 0) begin
          errors++;
          $display("[TB] FAIL missing_out: out_valid %b expected 1", out_valid);
        end
      end
    end
  end

  initial begin : driver
    logic           we;
    logic [AWL-1:0] wrd;
    logic [DWL-1:0] wd;
    wb_t            w;

    clrn = 1'b0;
    in_valid = 1'b0; in_aluc = '0; in_rs = '0; in_rt = '0; in_rd = '0;
    out_ready = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    clearModel();
    #3;
    checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset_a", a, 32'd0);
    checkOutput("reset_b", b, 32'd0);
    checkOutput("reset_aluc", {30'b0, aluc}, 32'd0);
    checkOutput("reset_rd", {27'b0, rd}, 32'd0);
    @(negedge clk);
    #2;
    clrn = 1'b1;

    $display("[TB] reset then init");
    applyStimulus(1'b0, ALUC_AND, '0, '0, '0, 1'b1, 1'b1, 5'd1, 32'h0000_0005);
    applyStimulus(1'b0, ALUC_AND, '0, '0, '0, 1'b1, 1'b1, 5'd2, 32'h0000_0003);
    applyStimulus(1'b1, ALUC_ADD, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, '0, '0);
    #1;
    checkOutput("init_out_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("init_a", a, 32'd5);
    checkOutput("init_b", b, 32'd3);
    checkOutput("init_aluc", {30'b0, aluc}, 32'd2);
    checkOutput("init_rd", {27'b0, rd}, 32'd3);

    $display("[TB] RAW stall");
    applyStimulus(1'b1, ALUC_SUB, 5'd3, 5'd1, 5'd4, 1'b1, 1'b0, '0, '0);
    applyStimulus(1'b1, ALUC_SUB, 5'd3, 5'd1, 5'd4, 1'b1, 1'b0, '0, '0);
    applyStimulus(1'b1, ALUC_SUB, 5'd3, 5'd1, 5'd4, 1'b1, 1'b1, 5'd3, 32'd8);
    #1;
    checkOutput("raw_a", a, 32'd8);
    checkOutput("raw_b", b, 32'd5);

    $display("[TB] backpressure");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, ALUC_AND, 5'd1, 5'd2, 5'd6, 1'b0, 1'b0, '0, '0);
    end
    #1;
    checkOutput("hold_a", a, 32'd8);
    checkOutput("hold_aluc", {30'b0, aluc}, {30'b0, ALUC_SUB});

    $display("[TB] r0 rules");
    applyStimulus(1'b0, ALUC_AND, '0, '0, '0, 1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF);
    applyStimulus(1'b1, ALUC_OR, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, '0, '0);
    #1;
    checkOutput("r0_a", a, 32'd0);
    checkOutput("r0_b", b, 32'd0);
    applyStimulus(1'b1, ALUC_ADD, 5'd0, 5'd1, 5'd0, 1'b1, 1'b0, '0, '0);

    $display("[TB] WAW and coincident set/clear");
    applyStimulus(1'b1, ALUC_ADD, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, '0, '0);
    applyStimulus(1'b1, ALUC_OR, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 5'd5, 32'h77);
    applyStimulus(1'b1, ALUC_AND, 5'd5, 5'd1, 5'd7, 1'b1, 1'b0, '0, '0);
    applyStimulus(1'b1, ALUC_AND, 5'd5, 5'd1, 5'd7, 1'b1, 1'b1, 5'd5, 32'h99);
    idle(1'b1);

    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, ALUC_ADD, 5'd1, 5'd2, 5'd9, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    #2;
    in_valid = 1'b0; wb_we = 1'b0;
    clrn = 1'b0;
    #1;
    checkOutput("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("midrst_a", a, 32'd0);
    checkOutput("midrst_b", b, 32'd0);
    checkOutput("midrst_rd", {27'b0, rd}, 32'd0);
    clearModel();
    @(negedge clk);
    #2;
    clrn = 1'b1;
    applyStimulus(1'b1, ALUC_ADD, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0, '0, '0);
    #1;
    checkOutput("post_rst_a", a, 32'd0);
    checkOutput("post_rst_b", b, 32'd0);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      we = 1'b0; wrd = '0; wd = '0;
      if ((alu_wb_q.size() > 0) && ($urandom_range(0, 2) != 0)) begin
        w = alu_wb_q.pop_front();
        we = 1'b1; wrd = w.rd; wd = w.data;
      end else if ($urandom_range(0, 4) == 0) begin
        we = 1'b1; wrd = AWL'($urandom_range(0, 7)); wd = $urandom;
      end
      applyStimulus($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                    AWL'($urandom_range(0, 7)), AWL'($urandom_range(0, 7)), AWL'($urandom_range(0, 7)),
                    $urandom_range(0, 3) != 0, we, wrd, wd);
    end

    for (int i = 0; i < 3; i++) idle(1'b1);
    checkOutput("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
